// File: rtl/slave_port.sv
// Bus-side slave endpoint. It deserialises a 16-bit address (6-bit device ID, then a 10-bit
// local address), then either collects 8 write bits or fetches a byte and shifts it back.
module slave_port #(
  parameter logic [5:0] SLAVE_ID = 6'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic       wr_bus,
  input  logic       master_valid,
  output logic       slave_ready,
  output logic       ack,
  output logic       rd_bus,
  output logic       slave_valid,
  input  logic       master_ready,
  output logic [9:0] s_addr,
  output logic [7:0] s_wr_data,
  output logic       s_wr_en,
  output logic       s_rd_en,
  input  logic [7:0] s_rd_data
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WR_DATA,
    WR_COMMIT,
    RD_FETCH,
    RD_LOAD,
    RD_DATA,
    IGNORE
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] addr_sr, addr_sr_nxt;
  logic [7:0]  data_sr, data_sr_nxt;
  logic        mode_r, mode_r_nxt;

  logic        ready_c, valid_c, ack_c, wr_en_c, rd_en_c;
  logic        id_match;
  logic        unused_addr_msb;

  // The sixth address bit is still on wr_bus when the ID decision is made.
  assign id_match = ({addr_sr[4:0], wr_bus} == SLAVE_ID);

  // The oldest address bit falls off the shifter and is never read.
  assign unused_addr_msb = addr_sr[15];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_sr <= '0;
      data_sr <= '0;
      mode_r  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the same pre-edge values.
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      addr_sr <= addr_sr_nxt;
      data_sr <= data_sr_nxt;
      mode_r  <= mode_r_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first, so no branch of the case below can leave a signal unassigned and infer a latch.
    state_nxt   = state;
    cnt_nxt     = cnt;
    addr_sr_nxt = addr_sr;
    data_sr_nxt = data_sr;
    mode_r_nxt  = mode_r;
    ready_c     = 1'b0;
    valid_c     = 1'b0;
    ack_c       = 1'b0;
    wr_en_c     = 1'b0;
    rd_en_c     = 1'b0;

    unique case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (master_valid) begin
          addr_sr_nxt = {addr_sr[14:0], wr_bus};
          cnt_nxt     = 4'd1;
          state_nxt   = ADDR;
        end
      end

      ADDR: begin
        ready_c = 1'b1;
        ack_c   = (cnt == 4'd5) & master_valid & id_match;
        if (master_valid) begin
          addr_sr_nxt = {addr_sr[14:0], wr_bus};
          cnt_nxt     = cnt + 4'd1;
          if ((cnt == 4'd5) && !id_match) begin
            state_nxt = IGNORE;
          end else if (cnt == 4'd15) begin
            mode_r_nxt = mode;
            state_nxt  = mode ? WR_DATA : RD_FETCH;
          end
        end
      end

      IGNORE: begin
        // Another slave owns the transaction; wait for a fully quiet bus before re-arming.
        if (!master_valid && !master_ready) begin
          state_nxt = IDLE;
        end
      end

      WR_DATA: begin
        ready_c = 1'b1;
        if (master_valid) begin
          data_sr_nxt = {data_sr[6:0], wr_bus};
          cnt_nxt     = cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt_nxt   = 4'd0;
            state_nxt = WR_COMMIT;
          end
        end
      end

      WR_COMMIT: begin
        wr_en_c   = mode_r;
        state_nxt = IDLE;
      end

      RD_FETCH: begin
        rd_en_c   = ~mode_r;
        state_nxt = RD_LOAD;
      end

      RD_LOAD: begin
        data_sr_nxt = s_rd_data;
        state_nxt   = RD_DATA;
      end

      RD_DATA: begin
        valid_c = 1'b1;
        if (master_ready) begin
          data_sr_nxt = {data_sr[6:0], 1'b0};
          cnt_nxt     = cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt_nxt   = 4'd0;
            state_nxt = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Every output is held low while rst is asserted, the combinational ones included.
  assign slave_ready = ready_c & ~rst;
  assign slave_valid = valid_c & ~rst;
  assign ack         = ack_c & ~rst;
  assign rd_bus      = valid_c & data_sr[7] & ~rst;
  assign s_wr_en     = wr_en_c & ~rst;
  assign s_rd_en     = rd_en_c & ~rst;
  assign s_addr      = rst ? 10'd0 : addr_sr[9:0];
  assign s_wr_data   = rst ? 8'd0 : data_sr;

endmodule

// File: tb/tb_slave_port.sv
// Self-checking bench for slave_port: a bit-level master, an attached memory, and a
// transaction-level reference memory that predicts every write and read.
`timescale 1ns/1ps
module tb_slave_port;

  localparam logic [5:0] SID = 6'd1;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode, wr_bus, master_valid, master_ready;
  logic       slave_ready, ack, rd_bus, slave_valid, s_wr_en, s_rd_en;
  logic [9:0] s_addr;
  logic [7:0] s_wr_data, s_rd_data;

  int n_checks = 0;
  int n_pass   = 0;
  int ack_cnt  = 0;

  logic [7:0]  mem     [1024];
  logic [7:0]  ref_mem [1024];
  logic [17:0] wr_q [$];
  logic [9:0]  rd_q [$];

  always #5 clk = ~clk;

  slave_port #(.SLAVE_ID(SID)) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .wr_bus       (wr_bus),
    .master_valid (master_valid),
    .slave_ready  (slave_ready),
    .ack          (ack),
    .rd_bus       (rd_bus),
    .slave_valid  (slave_valid),
    .master_ready (master_ready),
    .s_addr       (s_addr),
    .s_wr_data    (s_wr_data),
    .s_wr_en      (s_wr_en),
    .s_rd_en      (s_rd_en),
    .s_rd_data    (s_rd_data)
  );

  // Attached local memory with one cycle of read latency.
  always @(posedge clk) begin
    if (s_wr_en === 1'b1) mem[s_addr] <= s_wr_data;
    if (s_rd_en === 1'b1) s_rd_data <= mem[s_addr];
  end

  always @(negedge clk) begin
    if (s_wr_en === 1'b1) wr_q.push_back({s_addr, s_wr_data});
    if (s_rd_en === 1'b1) rd_q.push_back(s_addr);
    if (ack === 1'b1) ack_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int gap_of(input int gmode);
    if (gmode == 1) return 1;
    if (gmode == 2 && $urandom_range(0, 3) == 0) return int'($urandom_range(1, 2));
    return 0;
  endfunction

  task automatic send_bit(input logic b, input int gap, output logic ack_s);
    ack_s = 1'b0;
    repeat (gap) begin
      master_valid = 1'b0;
      step();
    end
    master_valid = 1'b1;
    wr_bus       = b;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (slave_ready === 1'b1) begin
        ack_s = ack;
        step();
        master_valid = 1'b0;
        return;
      end
      step();
    end
    n_checks++;
    $display("FAIL send_bit_timeout: slave_ready=%b, required 1 within 40 cycles", slave_ready);
    master_valid = 1'b0;
  endtask

  task automatic do_txn(input logic [5:0] id, input logic [9:0] la, input logic m,
                        input logic [7:0] d, input int gmode, input int stall_at,
                        input int stall_len);
    logic [15:0] a;
    logic [7:0]  exp_b, got;
    logic        hit, ak, exp_ak, done;
    int          ack0, lat, seen;
    a     = {id, la};
    hit   = (id == SID);
    ack0  = ack_cnt;
    mode  = m;
    for (int i = 0; i < 16; i++) begin
      if (hit || i < 6) begin
        send_bit(a[15-i], gap_of(gmode), ak);
        exp_ak = hit && (i == 5);
        n_checks++;
        if (ak !== exp_ak) $display("FAIL ack_bit%0d: ack=%b, required %b", i, ak, exp_ak);
        else n_pass++;
      end else begin
        master_valid = 1'b1;
        wr_bus       = a[15-i];
        @(negedge clk);
        n_checks++;
        if (slave_ready !== 1'b0) $display("FAIL ignore_ready: slave_ready=%b, required 0", slave_ready);
        else n_pass++;
        step();
      end
    end

    if (!hit) begin
      if (m) begin
        for (int i = 0; i < 8; i++) begin
          master_valid = 1'b1;
          wr_bus       = d[7-i];
          @(negedge clk);
          n_checks++;
          if (slave_ready !== 1'b0) $display("FAIL ignore_data_ready: slave_ready=%b, required 0", slave_ready);
          else n_pass++;
          step();
        end
      end
      master_valid = 1'b0;
      step();
      @(negedge clk);
      n_checks++;
      if (slave_ready !== 1'b1) $display("FAIL ignore_exit: slave_ready=%b, required 1", slave_ready);
      else n_pass++;
      step();
      n_checks++;
      if (wr_q.size() != 0 || rd_q.size() != 0 || ack_cnt != ack0)
        $display("FAIL miss_side_effects: wr=%0d rd=%0d acks=%0d, required 0 0 0",
                 wr_q.size(), rd_q.size(), ack_cnt - ack0);
      else n_pass++;
      wr_q.delete();
      rd_q.delete();
      return;
    end

    if (m) begin
      for (int i = 0; i < 8; i++) send_bit(d[7-i], gap_of(gmode), ak);
      step();
      n_checks++;
      if (wr_q.size() != 1 || wr_q[0] !== {la, d})
        $display("FAIL write_strobe: count=%0d first=%h, required count 1 with %h",
                 wr_q.size(), (wr_q.size() != 0) ? wr_q[0] : 18'h0, {la, d});
      else n_pass++;
      ref_mem[la] = d;
    end else begin
      exp_b = ref_mem[la];
      got   = 8'h00;
      lat   = 0;
      seen  = 0;
      for (int i = 0; i < 8; i++) begin
        done = 1'b0;
        for (int t = 0; t < 40 && !done; t++) begin
          master_ready = !((i == stall_at) && (t < stall_len)) &&
                         !((gmode == 2) && ($urandom_range(0, 3) == 0));
          @(negedge clk);
          if (seen == 0) lat++;
          if (slave_valid === 1'b1) begin
            seen = 1;
            if (master_ready) begin
              got[7-i] = rd_bus;
              done     = 1'b1;
            end else begin
              n_checks++;
              if (rd_bus !== exp_b[7-i]) $display("FAIL rd_hold_bit%0d: rd_bus=%b, required %b", i, rd_bus, exp_b[7-i]);
              else n_pass++;
            end
          end
          step();
        end
        if (!done) begin
          n_checks++;
          $display("FAIL read_timeout_bit%0d: slave_valid=%b, required 1 within 40 cycles", i, slave_valid);
        end
      end
      master_ready = 1'b0;
      n_checks++;
      if (got !== exp_b) $display("FAIL read_data: got %h, required %h", got, exp_b);
      else n_pass++;
      n_checks++;
      if (lat != 3) $display("FAIL read_latency: %0d cycles, required 3", lat);
      else n_pass++;
      n_checks++;
      if (rd_q.size() != 1 || rd_q[0] !== la)
        $display("FAIL read_strobe: count=%0d first=%h, required count 1 with %h",
                 rd_q.size(), (rd_q.size() != 0) ? rd_q[0] : 10'h0, la);
      else n_pass++;
    end
    n_checks++;
    if ((m ? rd_q.size() : wr_q.size()) != 0 || ack_cnt - ack0 != 1)
      $display("FAIL txn_side_effects: stray strobes=%0d acks=%0d, required 0 and 1",
               m ? rd_q.size() : wr_q.size(), ack_cnt - ack0);
    else n_pass++;
    wr_q.delete();
    rd_q.delete();
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    master_valid = 1'b1;
    wr_bus       = 1'b1;
    #2;
    n_checks++;
    if ({slave_ready, ack, rd_bus, slave_valid, s_wr_en, s_rd_en, s_addr, s_wr_data} !== 24'd0)
      $display("FAIL reset_outputs: %h, required 0",
               {slave_ready, ack, rd_bus, slave_valid, s_wr_en, s_rd_en, s_addr, s_wr_data});
    else n_pass++;
    master_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (slave_ready !== 1'b1 || ack !== 1'b0)
      $display("FAIL reset_release: ready=%b ack=%b, required 1 0", slave_ready, ack);
    else n_pass++;
    step();
  endtask

  task automatic test_write_hit();
    do_txn(SID, 10'h005, 1'b1, 8'hA5, 0, -1, 0);
  endtask

  task automatic test_read_hit();
    mem[10'h3FF]     = 8'h3C;
    ref_mem[10'h3FF] = 8'h3C;
    do_txn(SID, 10'h3FF, 1'b0, 8'h00, 0, -1, 0);
  endtask

  task automatic test_id_miss();
    do_txn(6'd2, 10'h005, 1'b1, 8'hC3, 0, -1, 0);
    do_txn(SID, 10'h006, 1'b1, 8'h96, 0, -1, 0);
  endtask

  task automatic test_backpressure();
    do_txn(SID, 10'h123, 1'b1, 8'h5A, 1, -1, 0);
    mem[10'h2AA]     = 8'hF0;
    ref_mem[10'h2AA] = 8'hF0;
    do_txn(SID, 10'h2AA, 1'b0, 8'h00, 0, 3, 3);
  endtask

  task automatic test_reset_mid();
    logic [15:0] a;
    logic [7:0]  d;
    logic        ak;
    a    = {SID, 10'h001};
    d    = 8'hEE;
    mode = 1'b1;
    for (int i = 0; i < 16; i++) send_bit(a[15-i], 0, ak);
    for (int i = 0; i < 4; i++) send_bit(d[7-i], 0, ak);
    #3 rst = 1'b1;
    master_valid = 1'b0;
    #1;
    n_checks++;
    if ({slave_ready, ack, rd_bus, slave_valid, s_wr_en, s_rd_en, s_addr, s_wr_data} !== 24'd0)
      $display("FAIL midreset_outputs: %h, required 0",
               {slave_ready, ack, rd_bus, slave_valid, s_wr_en, s_rd_en, s_addr, s_wr_data});
    else n_pass++;
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (slave_ready !== 1'b1 || wr_q.size() != 0)
      $display("FAIL midreset_abort: ready=%b writes=%0d, required 1 0", slave_ready, wr_q.size());
    else n_pass++;
    step();
    do_txn(SID, 10'h001, 1'b1, 8'h11, 0, -1, 0);
    do_txn(SID, 10'h001, 1'b0, 8'h00, 0, -1, 0);
  endtask

  task automatic test_back_to_back();
    logic [9:0] la;
    for (int k = 0; k < 3; k++) begin
      la = 10'($urandom);
      do_txn(SID, la, 1'b1, 8'($urandom), 0, -1, 0);
      do_txn(SID, la, 1'b0, 8'h00, 0, -1, 0);
    end
  endtask

  task automatic test_random();
    logic [5:0] id;
    for (int k = 0; k < 30; k++) begin
      id = SID;
      if ($urandom_range(0, 3) == 0) id = SID ^ 6'($urandom_range(1, 63));
      do_txn(id, 10'($urandom), 1'($urandom), 8'($urandom), 2, -1, 0);
    end
  endtask

  initial begin
    mode         = 1'b0;
    wr_bus       = 1'b0;
    master_valid = 1'b0;
    master_ready = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_write_hit();
    test_read_hit();
    test_id_miss();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
